// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache controller: 32 lines x 8 halfword entries,
// same-cycle hit lookup and an in-order 8-beat line fill from memory.
module icache_fill_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [15:0] fetch_addr,
    input  logic        flush,
    output logic [15:0] instr,
    output logic        cache_stall,
    output logic        mem_rd_en,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_data,
    input  logic        mem_data_valid
);

    localparam int unsigned TAG_W  = 7;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned OFF_W  = 3;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned LINES  = 32;
    localparam int unsigned WORDS  = 256;

    typedef enum logic {
        IDLE,
        FILL
    } state_e;

    state_e             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   fill_tag_q, fill_tag_d;
    logic [IDX_W-1:0]   fill_idx_q, fill_idx_d;
    logic [OFF_W-1:0]   issue_cnt_q, issue_cnt_d;
    logic [OFF_W-1:0]   recv_cnt_q, recv_cnt_d;
    logic               issue_done_q, issue_done_d;

    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [DATA_W-1:0]  data_mem [WORDS];

    logic [TAG_W-1:0]   fetch_tag_c;
    logic [IDX_W-1:0]   fetch_idx_c;
    logic [OFF_W-1:0]   fetch_off_c;
    logic               lookup_hit_c;
    logic               data_we_c;
    logic               tag_we_c;
    logic               unused_addr_lsb_c;

    assign fetch_tag_c       = fetch_addr[15:9];
    assign fetch_idx_c       = fetch_addr[8:4];
    assign fetch_off_c       = fetch_addr[3:1];
    assign unused_addr_lsb_c = fetch_addr[0];
    assign lookup_hit_c      = valid_q[fetch_idx_c] && (tag_mem[fetch_idx_c] == fetch_tag_c);

    // Next-state, lookup response and memory request generation
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        fill_tag_d   = fill_tag_q;
        fill_idx_d   = fill_idx_q;
        issue_cnt_d  = issue_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        issue_done_d = issue_done_q;
        instr        = 16'h0000;
        cache_stall  = 1'b0;
        mem_rd_en    = 1'b0;
        mem_addr     = 16'h0000;
        data_we_c    = 1'b0;
        tag_we_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (fetch_valid) begin
                    if (lookup_hit_c) begin
                        instr = data_mem[{fetch_idx_c, fetch_off_c}];
                    end else begin
                        cache_stall  = 1'b1;
                        fill_tag_d   = fetch_tag_c;
                        fill_idx_d   = fetch_idx_c;
                        issue_cnt_d  = '0;
                        recv_cnt_d   = '0;
                        issue_done_d = 1'b0;
                        state_d      = FILL;
                    end
                end
            end
            FILL: begin
                cache_stall = 1'b1;
                if (!issue_done_q) begin
                    mem_rd_en   = 1'b1;
                    mem_addr    = {fill_tag_q, fill_idx_q, issue_cnt_q, 1'b0};
                    issue_cnt_d = OFF_W'(issue_cnt_q + 1'b1);
                    if (issue_cnt_q == OFF_W'(7)) begin
                        issue_done_d = 1'b1;
                    end
                end
                if (mem_data_valid) begin
                    data_we_c  = 1'b1;
                    recv_cnt_d = OFF_W'(recv_cnt_q + 1'b1);
                    if (recv_cnt_q == OFF_W'(7)) begin
                        tag_we_c             = 1'b1;
                        valid_d[fill_idx_q]  = 1'b1;
                        issue_cnt_d          = '0;
                        recv_cnt_d           = '0;
                        issue_done_d         = 1'b0;
                        state_d              = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush overrides a completing fill: the new line stays invalid
        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            fill_tag_q   <= '0;
            fill_idx_q   <= '0;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            issue_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            fill_tag_q   <= fill_tag_d;
            fill_idx_q   <= fill_idx_d;
            issue_cnt_q  <= issue_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
            issue_done_q <= issue_done_d;
        end
    end

    // Tag and data arrays carry no reset; the valid bits gate their use
    always_ff @(posedge clk) begin
        if (data_we_c) begin
            data_mem[{fill_idx_q, recv_cnt_q}] <= mem_data;
        end
        if (tag_we_c) begin
            tag_mem[fill_idx_q] <= fill_tag_q;
        end
    end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: directed scenarios plus randomized traffic checked
// against a line-level cache model and an in-order random-latency memory.
module tb_icache_fill_ctrl;

    logic        clk;
    logic        rst;
    logic        fetch_valid;
    logic [15:0] fetch_addr;
    logic        flush;
    logic [15:0] instr;
    logic        cache_stall;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_data_valid;

    icache_fill_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_valid    (fetch_valid),
        .fetch_addr     (fetch_addr),
        .flush          (flush),
        .instr          (instr),
        .cache_stall    (cache_stall),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_data_valid (mem_data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;

    // reference cache: what is resident, and the line being fetched
    logic [31:0] m_valid;
    logic [6:0]  m_tag  [32];
    logic [15:0] m_data [256];
    logic        m_busy;
    logic [15:0] m_fill_base;
    int          m_recv;
    logic [15:0] m_exp_req [$];

    // memory responder: in-order, per-request random latency
    int          rq_ready [$];
    logic [15:0] rq_addr  [$];
    int          last_ready;
    int          lat_lo, lat_hi;
    logic        drain;
    logic        auto_flush_last;
    logic        obs_stall;
    int          n_rd;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic fv_in, input logic [15:0] fa, input logic fl, input logic rs);
        logic        fv, was_busy, hit, rv, efl, e_stall, e_rd;
        logic [15:0] rd, radr, e_instr, e_addr;
        logic [6:0]  t;
        logic [4:0]  ix;
        logic [7:0]  w;
        int          rdy;
        @(negedge clk);
        fv = fv_in;
        if (drain && rq_ready.size() == 0) drain = 1'b0;
        if (drain || !rs) fv = 1'b0;
        rv   = (rq_ready.size() > 0) && (rq_ready[0] <= cyc);
        radr = rv ? rq_addr[0] : 16'h0000;
        rd   = 16'($urandom);
        efl  = fl | (auto_flush_last && m_busy && rv && m_recv == 7);

        rst            = rs;
        fetch_valid    = fv;
        fetch_addr     = fa;
        flush          = efl;
        mem_data_valid = rv;
        mem_data       = rd;
        #1;

        t   = fa[15:9];
        ix  = fa[8:4];
        w   = fa[8:1];
        hit = !m_busy && fv && m_valid[ix] && (m_tag[ix] == t);
        e_instr = 16'h0000;
        e_stall = 1'b0;
        e_rd    = 1'b0;
        e_addr  = 16'h0000;
        if (m_busy) begin
            e_stall = 1'b1;
            if (m_exp_req.size() > 0) begin
                e_rd   = 1'b1;
                e_addr = m_exp_req[0];
            end
        end else if (fv) begin
            if (hit) e_instr = m_data[w];
            else     e_stall = 1'b1;
        end

        obs_stall = cache_stall;
        if (!rs) begin
            chk("rst_rd_en", 16'(mem_rd_en), 16'h0000);
            chk("rst_mem_addr", mem_addr, 16'h0000);
        end else begin
            chk("instr", instr, e_instr);
            chk("cache_stall", 16'(cache_stall), 16'(e_stall));
            chk("mem_rd_en", 16'(mem_rd_en), 16'(e_rd));
            if (e_rd) chk("mem_addr", mem_addr, e_addr);
        end

        if (e_rd && rs) void'(m_exp_req.pop_front());
        if (mem_rd_en) begin
            n_rd++;
            rdy = cyc + $urandom_range(lat_lo, lat_hi);
            if (rdy < last_ready) rdy = last_ready;
            last_ready = rdy;
            rq_ready.push_back(rdy);
            rq_addr.push_back(mem_addr);
        end
        if (rv) begin
            void'(rq_ready.pop_front());
            void'(rq_addr.pop_front());
        end

        was_busy = m_busy;
        if (!rs) begin
            m_valid = '0;
            m_busy  = 1'b0;
            m_exp_req.delete();
            drain   = 1'b1;
        end else begin
            if (!was_busy && fv && !hit) begin
                m_busy      = 1'b1;
                m_fill_base = {t, ix, 4'h0};
                m_recv      = 0;
                for (int k = 0; k < 8; k++) m_exp_req.push_back(m_fill_base + 16'(2 * k));
            end
            if (was_busy && rv) begin
                m_data[radr[8:1]] = rd;
                m_recv++;
                if (m_recv == 8) begin
                    m_busy                   = 1'b0;
                    m_valid[m_fill_base[8:4]] = 1'b1;
                    m_tag[m_fill_base[8:4]]   = m_fill_base[15:9];
                end
            end
            if (efl) m_valid = '0;
        end
        cyc++;
    endtask

    // keep fetching until the stall drops, bounded
    task automatic drain_stall(input logic [15:0] fa, inout int n);
        while (obs_stall && n < 80) begin
            step(1'b1, fa, 1'b0, 1'b1);
            n++;
        end
        chk("fill_done", 16'(obs_stall), 16'h0000);
    endtask

    task automatic run_fill(input logic [15:0] fa, input logic [15:0] alt, output int n);
        n = 1;
        step(1'b1, fa, 1'b0, 1'b1);
        drain_stall(alt, n);
    endtask

    initial begin
        int n;
        rst = 1'b1; fetch_valid = 1'b0; fetch_addr = 16'h0000; flush = 1'b0;
        mem_data = 16'h0000; mem_data_valid = 1'b0;
        m_valid = '0; m_busy = 1'b0; m_recv = 0; m_fill_base = 16'h0000;
        last_ready = 0; drain = 1'b0; auto_flush_last = 1'b0; obs_stall = 1'b0; n_rd = 0;
        lat_lo = 4; lat_hi = 4;
        #1 rst = 1'b0;

        step(1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b1, 16'h0000, 1'b0, 1'b0);

        // cold miss at latency 4: stall cycles 0-12, hit on cycle 13
        n_rd = 0;
        run_fill(16'h0000, 16'h0000, n);
        chk("cold_cycles", 16'(n), 16'd14);
        chk("cold_reqs", 16'(n_rd), 16'd8);

        step(1'b1, 16'h000A, 1'b0, 1'b1);
        chk("hit_no_stall", 16'(obs_stall), 16'h0000);

        // conflict on index 0
        run_fill(16'h0200, 16'h0200, n);
        chk("conflict_cycles", 16'(n), 16'd14);
        run_fill(16'h0000, 16'h0000, n);
        chk("conflict_refill", 16'(n), 16'd14);

        // PC moves during a fill
        step(1'b0, 16'h0000, 1'b1, 1'b1);
        run_fill(16'h0000, 16'h1234, n);

        // flush on the last response of a fill
        auto_flush_last = 1'b1;
        step(1'b1, 16'h0100, 1'b0, 1'b1);
        n = 0;
        while (m_busy && n < 40) begin
            step(1'b0, 16'h0100, 1'b0, 1'b1);
            n++;
        end
        auto_flush_last = 1'b0;
        step(1'b1, 16'h0100, 1'b0, 1'b1);
        chk("flush_last_miss", 16'(obs_stall), 16'h0001);
        n = 1;
        drain_stall(16'h0100, n);

        // flush coinciding with a hit
        step(1'b1, 16'h0102, 1'b1, 1'b1);
        chk("flush_hit_stall", 16'(obs_stall), 16'h0000);
        step(1'b1, 16'h0102, 1'b0, 1'b1);
        chk("after_flush_miss", 16'(obs_stall), 16'h0001);
        n = 1;
        drain_stall(16'h0102, n);

        // reset in the middle of a fill, stale responses arrive afterwards
        step(1'b1, 16'h0040, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 16'h0040, 1'b0, 1'b1);
        step(1'b1, 16'h0040, 1'b0, 1'b0);
        step(1'b1, 16'h0040, 1'b0, 1'b0);
        n = 0;
        while (rq_ready.size() > 0 && n < 40) begin
            step(1'b0, 16'h0040, 1'b0, 1'b1);
            n++;
        end
        step(1'b1, 16'h0040, 1'b0, 1'b1);
        chk("rst_abort_miss", 16'(obs_stall), 16'h0001);
        n = 1;
        drain_stall(16'h0040, n);

        // randomized traffic over a small address pool
        lat_lo = 1; lat_hi = 6;
        for (int i = 0; i < 4000; i++) begin
            logic [15:0] fa;
            fa = {7'($urandom_range(0, 2)), 5'($urandom_range(0, 3)), 3'($urandom), 1'($urandom)};
            auto_flush_last = ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 9) < 8, fa, $urandom_range(0, 99) == 0, $urandom_range(0, 499) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/icache_fill_ctrl.md
ICACHE_FILL_CTRL -- requirements
Module: icache_fill_ctrl

Interface
REQ-001 SHALL have no parameters; geometry fixed: direct-mapped, 32 lines x 8 words x 16 bits, 16-bit byte address.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 fetch_valid  input  1  fetch stage presents a valid PC this cycle.
REQ-005 fetch_addr  input  16  PC from fetch stage; bit 0 ignored.
REQ-006 flush  input  1  invalidate all lines.
REQ-007 instr  output  16  instruction word to fetch stage.
REQ-008 cache_stall  output  1  fetch stage must hold PC.
REQ-009 mem_rd_en  output  1  one-cycle memory read request.
REQ-010 mem_addr  output  16  word-aligned read address, valid when mem_rd_en=1.
REQ-011 mem_data  input  16  read data from memory.
REQ-012 mem_data_valid  input  1  mem_data carries next in-order response.

Function
REQ-013 Address split SHALL be tag=[15:9], index=[8:4], word offset=[3:1].
REQ-014 State SHALL be a valid bit and 7-bit tag per line plus data array; data array not reset.
REQ-015 FSM states SHALL be IDLE and FILL only.
REQ-016 Hit = IDLE & fetch_valid & valid[index] & tag match; on hit, same cycle: instr=data[index][offset], cache_stall=0.
REQ-017 Miss = IDLE & fetch_valid & !hit; cache_stall=1 combinationally that cycle; latch tag/index of fetch_addr; IDLE->FILL at the edge.
REQ-018 In IDLE with fetch_valid=0: cache_stall=0, instr=16'h0000.
REQ-019 In FILL: cache_stall=1 every cycle; instr=16'h0000 (never opcode 0xF).
REQ-020 In FILL, 3-bit issue counter: mem_rd_en=1 while fewer than 8 requests issued, mem_addr={latched tag, latched index, issue_cnt, 1'b0}; one request per cycle, first in cycle after miss edge.
REQ-021 Each mem_data_valid in FILL SHALL write mem_data to data[latched index][recv_cnt] and increment 3-bit recv_cnt; mem_data_valid in IDLE ignored.
REQ-022 Memory latency SHALL be tolerated for any value >=1 cycle, responses in order.
REQ-023 On 8th response edge: write tag, set valid, clear counters, FILL->IDLE; next-cycle lookup re-evaluates fetch_addr (normally a hit).
REQ-024 fetch_addr/fetch_valid changes during FILL SHALL be ignored; fill always completes for latched line.
REQ-025 flush SHALL clear all valid bits at the edge, in any state; FILL continues.
REQ-026 flush coincident with fill completion: flush wins; filled line left invalid, FSM still returns to IDLE.
REQ-027 flush in IDLE same cycle as a hit: hit data still returned that cycle.

Reset
REQ-028 rst low SHALL immediately force IDLE, all valid bits 0, issue_cnt=recv_cnt=0, mem_rd_en=0, mem_addr=16'h0000.
REQ-029 Reset asserted mid-FILL SHALL abort fill; later responses after release in IDLE ignored; line stays invalid.
REQ-030 After release with fetch_valid=1: cycle 0 is a miss, cache_stall=1.

Verification
REQ-031 Cold miss, memory latency 4, fetch_addr=0x0000 at cycle 0 -> mem_rd_en cycles 1-8, mem_addr 0x0000..0x000E; data cycles 5-12; cache_stall=1 cycles 0-12; cycle 13 hit, instr=word0.
REQ-032 After REQ-031 fill, fetch_addr=0x000A -> same-cycle hit, instr=word5, no mem_rd_en.
REQ-033 Conflict: fill 0x0000, then fetch 0x0200 (same index, tag 1) -> miss, refill, then 0x0000 misses again.
REQ-034 Change fetch_addr to 0x1234 during FILL of 0x0000 -> requests stay 0x0000..0x000E; afterwards 0x1234 misses.
REQ-035 flush on 8th response cycle -> FSM IDLE, same address misses next cycle; flush on a hit cycle -> instr correct, next access misses.
REQ-036 rst low at cycle 4 of a fill, released cycle 6, remaining responses arrive -> no array write, valid=0, next fetch misses.
